// File: rtl/burst_memory__axi4_peripheral.sv
// Word-addressed AXI4 memory slave with multi-beat FIXED/INCR bursts (one B per AW burst, rlast on the final R beat).
// Optional WRAP burst support is enabled by defining AXI4_BURST_WRAP_EN.
module burst_memory__axi4_peripheral #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [LEN_WIDTH-1:0]     awlen,
  input  logic [2:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [LEN_WIDTH-1:0]     arlen,
  input  logic [2:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready
);

  localparam int                   DEPTH       = 2 ** ADDRESS_WIDTH;
  localparam logic [2:0]           BURST_FIXED = 3'b001;
  localparam logic [2:0]           BURST_INCR  = 3'b010;
`ifdef AXI4_BURST_WRAP_EN
  localparam logic [2:0]           BURST_WRAP  = 3'b100;
`endif
  localparam logic [1:0]           RESP_OKAY   = 2'b00;
  localparam logic [1:0]           RESP_SLVERR = 2'b10;
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO    = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE     = LEN_WIDTH'(1);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // A burst is in error when its length is zero or its burst code is not served.
  function automatic logic burst_err(input logic [2:0] burst, input logic [LEN_WIDTH-1:0] len);
    logic ok;
    case (burst)
      BURST_FIXED, BURST_INCR: ok = 1'b1;
`ifdef AXI4_BURST_WRAP_EN
      BURST_WRAP: ok = (len == LEN_WIDTH'(2)) || (len == LEN_WIDTH'(4)) ||
                       (len == LEN_WIDTH'(8)) || (len == LEN_WIDTH'(16));
`endif
      default: ok = 1'b0;
    endcase
    return !ok || (len == LEN_ZERO);
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(
    input logic [ADDRESS_WIDTH-1:0] addr,
    input logic [2:0]               burst
`ifdef AXI4_BURST_WRAP_EN
    , input logic [LEN_WIDTH-1:0]   len
`endif
  );
    logic [ADDRESS_WIDTH-1:0] res;
`ifdef AXI4_BURST_WRAP_EN
    logic [ADDRESS_WIDTH-1:0] mask;
    mask = ADDRESS_WIDTH'(len - LEN_ONE);
`endif
    case (burst)
      BURST_INCR: res = addr + ADDRESS_WIDTH'(1);
`ifdef AXI4_BURST_WRAP_EN
      BURST_WRAP: res = (addr & ~mask) | ((addr + ADDRESS_WIDTH'(1)) & mask);
`endif
      default:    res = addr;
    endcase
    return res;
  endfunction

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

  w_state_t                 r_w_state, w_w_state_n;
  logic                     r_awready, w_awready_n;
  logic                     r_wready, w_wready_n;
  logic                     r_bvalid, w_bvalid_n;
  logic [1:0]               r_bresp, w_bresp_n;
  logic [ADDRESS_WIDTH-1:0] r_w_addr, w_w_addr_n;
  logic [LEN_WIDTH-1:0]     r_w_len, w_w_len_n;
  logic [LEN_WIDTH-1:0]     r_w_cnt, w_w_cnt_n;
  logic [2:0]               r_w_burst, w_w_burst_n;
  logic                     r_w_err, w_w_err_n;
  logic                     r_w_skip, w_w_skip_n;
  logic                     w_mem_we;
  logic                     w_w_last_beat;
  logic [LEN_WIDTH-1:0]     w_awlen_eff;

  r_state_t                 r_r_state, w_r_state_n;
  logic                     r_arready, w_arready_n;
  logic                     r_rvalid, w_rvalid_n;
  logic                     r_rlast, w_rlast_n;
  logic [DATA_WIDTH-1:0]    r_rdata, w_rdata_n;
  logic [1:0]               r_rresp, w_rresp_n;
  logic [ADDRESS_WIDTH-1:0] r_r_addr, w_r_addr_n;
  logic [LEN_WIDTH-1:0]     r_r_len, w_r_len_n;
  logic [LEN_WIDTH-1:0]     r_r_cnt, w_r_cnt_n;
  logic [2:0]               r_r_burst, w_r_burst_n;
  logic                     r_r_skip, w_r_skip_n;
  logic [LEN_WIDTH-1:0]     w_arlen_eff;
  logic                     w_ar_err;

  assign w_awlen_eff   = (awlen == LEN_ZERO) ? LEN_ONE : awlen;
  assign w_arlen_eff   = (arlen == LEN_ZERO) ? LEN_ONE : arlen;
  assign w_ar_err      = burst_err(arburst, arlen);
  assign w_w_last_beat = (r_w_cnt == (r_w_len - LEN_ONE));

  // Write channel next-state and registered-output values.
  always_comb begin
    w_w_state_n = r_w_state;
    w_awready_n = r_awready;
    w_wready_n  = r_wready;
    w_bvalid_n  = r_bvalid;
    w_bresp_n   = r_bresp;
    w_w_addr_n  = r_w_addr;
    w_w_len_n   = r_w_len;
    w_w_cnt_n   = r_w_cnt;
    w_w_burst_n = r_w_burst;
    w_w_err_n   = r_w_err;
    w_w_skip_n  = r_w_skip;
    w_mem_we    = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if (awvalid && r_awready) begin
          w_w_addr_n  = awaddr;
          w_w_len_n   = w_awlen_eff;
          w_w_burst_n = awburst;
          w_w_skip_n  = burst_err(awburst, awlen);
          w_w_err_n   = burst_err(awburst, awlen);
          w_w_cnt_n   = LEN_ZERO;
          w_awready_n = 1'b0;
          w_wready_n  = 1'b1;
          w_w_state_n = W_DATA;
        end else begin
          w_awready_n = 1'b1;
        end
      end
      W_DATA: begin
        if (wvalid && r_wready) begin
          w_mem_we   = !r_w_skip;
`ifdef AXI4_BURST_WRAP_EN
          w_w_addr_n = next_addr(r_w_addr, r_w_burst, r_w_len);
`else
          w_w_addr_n = next_addr(r_w_addr, r_w_burst);
`endif
          w_w_cnt_n  = r_w_cnt + LEN_ONE;
          // wlast must coincide exactly with the counted final beat.
          w_w_err_n  = r_w_err | (wlast != w_w_last_beat);
          if (w_w_last_beat || wlast) begin
            w_wready_n  = 1'b0;
            w_bvalid_n  = 1'b1;
            w_bresp_n   = w_w_err_n ? RESP_SLVERR : RESP_OKAY;
            w_w_state_n = W_RESP;
          end else begin
            w_wready_n  = 1'b1;
          end
        end else begin
          w_wready_n = r_wready;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_bvalid_n  = 1'b0;
          w_bresp_n   = RESP_OKAY;
          w_awready_n = 1'b1;
          w_w_state_n = W_IDLE;
        end else begin
          w_bvalid_n  = 1'b1;
        end
      end
      default: begin
        w_w_state_n = W_IDLE;
        w_awready_n = 1'b1;
        w_wready_n  = 1'b0;
        w_bvalid_n  = 1'b0;
      end
    endcase
  end

  // Read channel: the next beat is fetched on the same edge that retires the current one.
  always_comb begin
    w_r_state_n = r_r_state;
    w_arready_n = r_arready;
    w_rvalid_n  = r_rvalid;
    w_rlast_n   = r_rlast;
    w_rdata_n   = r_rdata;
    w_rresp_n   = r_rresp;
    w_r_addr_n  = r_r_addr;
    w_r_len_n   = r_r_len;
    w_r_cnt_n   = r_r_cnt;
    w_r_burst_n = r_r_burst;
    w_r_skip_n  = r_r_skip;
    case (r_r_state)
      R_IDLE: begin
        if (arvalid && r_arready) begin
          w_r_addr_n  = araddr;
          w_r_len_n   = w_arlen_eff;
          w_r_burst_n = arburst;
          w_r_skip_n  = w_ar_err;
          w_r_cnt_n   = LEN_ZERO;
          w_arready_n = 1'b0;
          w_rvalid_n  = 1'b1;
          w_rlast_n   = (w_arlen_eff == LEN_ONE);
          w_rdata_n   = w_ar_err ? DATA_WIDTH'(0) : r_mem[araddr];
          w_rresp_n   = w_ar_err ? RESP_SLVERR : RESP_OKAY;
          w_r_state_n = R_DATA;
        end else begin
          w_arready_n = 1'b1;
        end
      end
      R_DATA: begin
        if (r_rvalid && rready && r_rlast) begin
          w_rvalid_n  = 1'b0;
          w_rlast_n   = 1'b0;
          w_rdata_n   = DATA_WIDTH'(0);
          w_rresp_n   = RESP_OKAY;
          w_arready_n = 1'b1;
          w_r_state_n = R_IDLE;
        end else if (r_rvalid && rready) begin
`ifdef AXI4_BURST_WRAP_EN
          w_r_addr_n = next_addr(r_r_addr, r_r_burst, r_r_len);
`else
          w_r_addr_n = next_addr(r_r_addr, r_r_burst);
`endif
          w_r_cnt_n  = r_r_cnt + LEN_ONE;
          w_rlast_n  = (w_r_cnt_n == (r_r_len - LEN_ONE));
          w_rdata_n  = r_r_skip ? DATA_WIDTH'(0) : r_mem[w_r_addr_n];
        end else begin
          w_rvalid_n = r_rvalid;
        end
      end
      default: begin
        w_r_state_n = R_IDLE;
        w_arready_n = 1'b1;
        w_rvalid_n  = 1'b0;
        w_rlast_n   = 1'b0;
      end
    endcase
  end

  // Control and output registers for both channels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_w_addr  <= ADDRESS_WIDTH'(0);
      r_w_len   <= LEN_ZERO;
      r_w_cnt   <= LEN_ZERO;
      r_w_burst <= 3'b000;
      r_w_err   <= 1'b0;
      r_w_skip  <= 1'b0;
      r_r_state <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= DATA_WIDTH'(0);
      r_rresp   <= RESP_OKAY;
      r_r_addr  <= ADDRESS_WIDTH'(0);
      r_r_len   <= LEN_ZERO;
      r_r_cnt   <= LEN_ZERO;
      r_r_burst <= 3'b000;
      r_r_skip  <= 1'b0;
    end else begin
      r_w_state <= w_w_state_n;
      r_awready <= w_awready_n;
      r_wready  <= w_wready_n;
      r_bvalid  <= w_bvalid_n;
      r_bresp   <= w_bresp_n;
      r_w_addr  <= w_w_addr_n;
      r_w_len   <= w_w_len_n;
      r_w_cnt   <= w_w_cnt_n;
      r_w_burst <= w_w_burst_n;
      r_w_err   <= w_w_err_n;
      r_w_skip  <= w_w_skip_n;
      r_r_state <= w_r_state_n;
      r_arready <= w_arready_n;
      r_rvalid  <= w_rvalid_n;
      r_rlast   <= w_rlast_n;
      r_rdata   <= w_rdata_n;
      r_rresp   <= w_rresp_n;
      r_r_addr  <= w_r_addr_n;
      r_r_len   <= w_r_len_n;
      r_r_cnt   <= w_r_cnt_n;
      r_r_burst <= w_r_burst_n;
      r_r_skip  <= w_r_skip_n;
    end
  end

  // Storage is deliberately left out of reset so contents survive reset_n.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[r_w_addr] <= wdata;
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule
